// File: rtl/fsm_eg_param_if.sv
// Control/observation bundle for fsm_eg_param: enable, a/b controls and clear in; x/y/tmo, state and x_count out.
interface fsm_eg_param_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              en;
  logic              a;
  logic              b;
  logic              clr;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] y;
  logic              tmo;
  logic [1:0]        state;
  logic [CNT_W-1:0]  x_count;

  modport master (output en, a, b, clr, input x, y, tmo, state, x_count);
  modport slave  (input en, a, b, clr, output x, y, tmo, state, x_count);
endinterface

// File: rtl/fsm_eg_param.sv
// Parametrised a/b sequencing FSM with advance enable, S1 dwell timeout, saturating x-event counter
// and selectable combinational or registered x/y/tmo outputs.
//
//   state | meaning
//   S0    | idle, waiting for a (and b) with en
//   S1    | wait-release, y driven, dwell timer runs on en & !a
//   S2    | burst, x driven while en & a & b
//   S3    | timeout, one-cycle tmo pulse, back to S0
module fsm_eg_param #(
  parameter int DATA_W  = 8,
  parameter int X_VAL   = 168,
  parameter int Y_VAL   = 168,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8,
  parameter bit OUT_REG = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  fsm_eg_param_if.slave  bus
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  localparam int                DW_W    = $clog2(TIMEOUT + 1);
  localparam logic [DW_W-1:0]   DW_LAST = DW_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] X_V     = DATA_W'(X_VAL);
  localparam logic [DATA_W-1:0] Y_V     = DATA_W'(Y_VAL);

  state_t            state_q, state_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] x_c, y_c;
  logic              tmo_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    x_c     = '0;
    y_c     = '0;
    tmo_c   = 1'b0;
    case (state_q)
      S0: begin
        if (bus.en && bus.a && bus.b) begin
          x_c     = X_V;
          state_d = S2;
        end else if (bus.en && bus.a) begin
          state_d = S1;
          dwell_d = '0;
        end
      end
      S1: begin
        y_c = Y_V;
        if (bus.en && bus.a) begin
          state_d = S0;
        end else if (bus.en) begin
          // TIMEOUT en-cycles with a low, counting this one, force the exit
          if (dwell_q == DW_LAST) begin
            state_d = S3;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + DW_W'(1);
          end
        end
      end
      S2: begin
        if (bus.en) begin
          if (bus.a && bus.b) x_c = X_V;
          state_d = S0;
        end
      end
      S3: begin
        tmo_c   = 1'b1;
        state_d = S0;
      end
      default: state_d = S0;
    endcase
  end

  // Counts the pre-register x so the count timing is independent of OUT_REG
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (bus.clr) begin
      count_q <= '0;
    end else if (x_c != '0 && count_q != '1) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.state   = state_q;
  assign bus.x_count = count_q;

  generate
    if (OUT_REG) begin : g_reg
      logic [DATA_W-1:0] x_q, y_q;
      logic              tmo_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          x_q   <= '0;
          y_q   <= '0;
          tmo_q <= 1'b0;
        end else begin
          x_q   <= x_c;
          y_q   <= y_c;
          tmo_q <= tmo_c;
        end
      end
      assign bus.x   = x_q;
      assign bus.y   = y_q;
      assign bus.tmo = tmo_q;
    end else begin : g_comb
      // Mealy x could otherwise follow live inputs while reset holds the state
      assign bus.x   = rst ? '0 : x_c;
      assign bus.y   = rst ? '0 : y_c;
      assign bus.tmo = rst ? 1'b0 : tmo_c;
    end
  endgenerate

endmodule
